// File: rtl/ppi_pkg.sv
// ppi_pkg
// Shared definitions for the 8255-style PPI bus master:
//   - PPI register addresses (ports A/B/C and the control register)
//   - bus sequencer state encoding
//   - control-word field positions (mode-set flag, BSR bit select, BSR set/reset)
//   - width of the phase counter shared by the sequencer and its counter
package ppi_pkg;

    localparam int PHASE_CNT_W = 4;

    typedef enum logic [1:0] {
        PPI_PORT_A = 2'b00,
        PPI_PORT_B = 2'b01,
        PPI_PORT_C = 2'b10,
        PPI_CTRL   = 2'b11
    } ppi_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOV
    } state_t;

    // Control-register word layout. Bit 7 set selects a mode-set word,
    // clear selects a bit-set/reset (BSR) word for port C.
    localparam int CTRL_MODE_SET_BIT = 7;
    localparam int BSR_SEL_MSB       = 3;
    localparam int BSR_SEL_LSB       = 1;
    localparam int BSR_SET_BIT       = 0;

    // Builds a BSR control word that sets or clears one port-C bit.
    function automatic logic [7:0] bsr_word(input logic [2:0] bit_sel, input logic set);
        logic [7:0] w;
        w                          = '0;
        w[CTRL_MODE_SET_BIT]       = 1'b0;
        w[BSR_SEL_MSB:BSR_SEL_LSB] = bit_sel;
        w[BSR_SET_BIT]             = set;
        return w;
    endfunction

endpackage

// File: rtl/ppi_phase_counter.sv
// ppi_phase_counter
// Loadable down-counter that times each bus phase. The sequencer loads it
// with (phase length - 1) on every phase entry; it then counts down to zero
// and holds there. done is high while the count is zero, i.e. during the
// last cycle of the current phase.
// Ports:
//   CLK       in   clock
//   RST       in   synchronous active-high reset
//   load      in   load load_val at the next edge (takes priority over counting)
//   load_val  in   value to load
//   count     out  current count
//   done      out  count == 0
module ppi_phase_counter
    import ppi_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   load,
    input  logic [PHASE_CNT_W-1:0] load_val,
    output logic [PHASE_CNT_W-1:0] count,
    output logic                   done
);

    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/ppi_bus_master.sv
// ppi_bus_master
// Host-side sequencer for an 8255-style PPI. Accepts one read/write request
// at a time over valid/ready and plays it out on the PPI pins as
// SETUP -> STROBE -> HOLD -> RECOV, each phase a parameterised number of
// cycles. Every pin and response output comes straight from a register.
// Ports:
//   CLK, RST    clock, synchronous active-high reset
//   req_valid   in   request present
//   req_ready   out  block can accept a request (IDLE only)
//   req_write   in   1 = write, 0 = read
//   req_addr    in   PPI register address
//   req_wdata   in   write data
//   rsp_valid   out  one-cycle completion pulse (last HOLD cycle)
//   rsp_rdata   out  last read data, held until the next read
//   CS, RD, WR  out  active-low chip select and strobes
//   A           out  PPI address
//   D           io   PPI data; driven only while CS is low on a write
module ppi_bus_master
    import ppi_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1,
    parameter int unsigned RECOV_CYC = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [1:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic [1:0] A,
    inout  wire  [7:0] D
);

    localparam logic [PHASE_CNT_W-1:0] SETUP_LD = PHASE_CNT_W'(SETUP_CYC - 1);
    localparam logic [PHASE_CNT_W-1:0] PULSE_LD = PHASE_CNT_W'(PULSE_CYC - 1);
    localparam logic [PHASE_CNT_W-1:0] HOLD_LD  = PHASE_CNT_W'(HOLD_CYC - 1);
    localparam logic [PHASE_CNT_W-1:0] RECOV_LD = PHASE_CNT_W'(RECOV_CYC - 1);

    state_t                   state;
    logic                     wr_q;
    logic                     d_oe;
    logic [7:0]               d_out;
    logic                     accept;
    logic                     cnt_load;
    logic [PHASE_CNT_W-1:0]   cnt_val;
    logic [PHASE_CNT_W-1:0]   cnt;
    logic                     cnt_done;

    assign accept = req_valid && req_ready;
    assign D      = d_oe ? d_out : 8'hzz;

    // Reload the phase counter on every phase transition.
    always_comb begin
        // NOTE: every output of this block gets a default first so no
        // path through the case leaves it unassigned (no latch).
        cnt_load = 1'b0;
        cnt_val  = '0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    cnt_load = 1'b1;
                    cnt_val  = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (cnt_done) begin
                    cnt_load = 1'b1;
                    cnt_val  = PULSE_LD;
                end
            end
            ST_STROBE: begin
                if (cnt_done) begin
                    cnt_load = 1'b1;
                    cnt_val  = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (cnt_done) begin
                    cnt_load = 1'b1;
                    cnt_val  = RECOV_LD;
                end
            end
            ST_RECOV: begin
            end
            default: begin
            end
        endcase
    end

    ppi_phase_counter u_phase_counter (
        .CLK      (CLK),
        .RST      (RST),
        .load     (cnt_load),
        .load_val (cnt_val),
        .count    (cnt),
        .done     (cnt_done)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            wr_q      <= 1'b0;
            CS        <= 1'b1;
            RD        <= 1'b1;
            WR        <= 1'b1;
            A         <= PPI_PORT_A;
            d_oe      <= 1'b0;
            d_out     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_SETUP;
                        req_ready <= 1'b0;
                        wr_q      <= req_write;
                        A         <= req_addr;
                        d_out     <= req_wdata;
                        d_oe      <= req_write;
                        CS        <= 1'b0;
                    end else begin
                        // Also raises ready on the first edge after reset.
                        req_ready <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt_done) begin
                        state <= ST_STROBE;
                        RD    <= wr_q;
                        WR    <= !wr_q;
                    end
                end
                ST_STROBE: begin
                    if (cnt_done) begin
                        state <= ST_HOLD;
                        RD    <= 1'b1;
                        WR    <= 1'b1;
                        if (!wr_q) begin
                            rsp_rdata <= D;
                        end
                        // A one-cycle HOLD is also its final cycle.
                        rsp_valid <= (HOLD_CYC == 1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_done) begin
                        state <= ST_RECOV;
                        CS    <= 1'b1;
                        d_oe  <= 1'b0;
                    end else begin
                        // Count 1 now means the next cycle is the last one.
                        rsp_valid <= (cnt == PHASE_CNT_W'(1));
                    end
                end
                ST_RECOV: begin
                    if (cnt_done) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ppi_bus_master.md
# ppi_bus_master

Synchronous host-side bus sequencer that sits directly upstream of the 8255-style PPI and drives its CS, RD, WR, A and D pins. It accepts one read or write request at a time over a valid/ready handshake. It generates a parameterised setup/strobe/hold/recovery pin sequence and returns read data or a write acknowledge on a one-cycle response pulse. It converts the design's clocked command traffic into the asynchronous strobe protocol the PPI expects.

## Interface
- SETUP_CYC, default 1: cycles with CS low and A/D valid before the strobe falls. Legal range 1..15.
- PULSE_CYC, default 2: cycles the RD or WR strobe is held low. Legal range 1..15.
- HOLD_CYC, default 1: cycles CS, A and D are held after the strobe rises. Legal range 1..15.
- RECOV_CYC, default 1: cycles with CS high before the next request is accepted. Legal range 1..15.
- Clocking and reset (already decided): one clock, CLK; reset RST is synchronous and active-high.
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1 = write cycle, 0 = read cycle.
- req_addr  input  2  target: 00 = port A, 01 = port B, 10 = port C, 11 = control register.
- req_wdata  input  8  write data.
- rsp_valid  output  1  one-cycle pulse marking completion of the accepted request.
- rsp_rdata  output  8  read data; valid while rsp_valid is high on a read.
- CS  output  1  chip select, active low.
- RD  output  1  read strobe, active low.
- WR  output  1  write strobe, active low.
- A  output  2  PPI address.
- D  inout  8  PPI data bus; driven only during write cycles, otherwise high-Z.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, RECOV. A single phase counter is loaded on each state entry with that phase's cycle count minus 1.
- IDLE
  - req_ready = 1; CS, RD and WR are all 1; D is high-Z.
  - Acceptance is req_valid && req_ready at a rising edge.
  - On acceptance, req_write, req_addr and req_wdata are captured and the next state is SETUP.
- SETUP
  - CS = 0, A = captured address.
  - On a write, D = captured data.
  - Stays SETUP_CYC cycles, then goes to STROBE.
- STROBE
  - RD = 0 on a read; WR = 0 on a write.
  - Stays PULSE_CYC cycles.
  - On a read, D is sampled into rsp_rdata at the edge that ends the last STROBE cycle.
  - Then goes to HOLD.
- HOLD
  - RD and WR = 1; CS, A and (on a write) D are unchanged.
  - Stays HOLD_CYC cycles.
  - rsp_valid = 1 during the final HOLD cycle only.
  - Then goes to RECOV.
- RECOV
  - CS = 1; D is high-Z; A keeps its last value.
  - Stays RECOV_CYC cycles, then goes to IDLE.
- req_ready is 0 in every state except IDLE. req_valid asserted while busy is ignored. The request fields only need to be stable in the accept cycle.
- RD and WR are never both 0. No strobe is ever low while CS is 1.
- Writes to addr 11 are issued as normal bus cycles; the block does not decode mode-set vs. BSR words.
- Reads of addr 11 run as normal cycles; rsp_rdata returns whatever is on D.
- rsp_rdata holds its value until the next read capture. On a write response it keeps the previous read value.

## Timing
- Reset values, applied on the first edge with RST = 1:
  - state = IDLE.
  - CS = 1, RD = 1, WR = 1, A = 00, D = high-Z.
  - req_ready = 0 while RST = 1; req_ready = 1 on the first cycle after RST falls.
  - rsp_valid = 0, rsp_rdata = 00.
- Reset mid-operation: the cycle is aborted at the next edge. Strobes and CS are released together, and no rsp_valid is produced.
- With defaults, for a request accepted at edge 0:
  - CS falls after edge 0.
  - The strobe is low between edges 1 and 3.
  - rsp_valid is high between edges 3 and 4.
  - CS rises after edge 4.
  - req_ready is high after edge 5.
- Accept-to-next-accept: SETUP_CYC + PULSE_CYC + HOLD_CYC + RECOV_CYC + 1 cycles. This is 6 with defaults.
- Accept-to-response edge: SETUP_CYC + PULSE_CYC + HOLD_CYC cycles.
- Back-to-back: req_valid held high gives one accept every 6 cycles with defaults.
- All outputs are registered; there are no combinational paths from req_* to the pins.

## Structure
- Package ppi_pkg holds:
  - Address constants PPI_PORT_A, PPI_PORT_B, PPI_PORT_C, PPI_CTRL.
  - The state enum.
  - Control-word constants: mode-set flag bit 7; BSR bit-select field [3:1]; set/reset bit 0.
  - Phase counter width of 4.
- One sub-module, ppi_phase_counter: a loadable 4-bit down-counter with a done flag, instantiated once.

## Test plan
- Reset with defaults: hold RST for 3 cycles with req_valid = 1 -> CS/RD/WR = 1, D = Z, req_ready = 0, no accept; req_ready = 1 one cycle after RST falls.
- Write 0x80 to addr 11 -> CS low for 4 cycles, WR low for exactly 2 cycles, D = 0x80 and A = 11 throughout CS low, rsp_valid one pulse, next accept 6 cycles later.
- Read addr 00 with a bench model driving D = 0x88 only while RD = 0 -> rsp_rdata = 0x88 on the rsp_valid pulse; D undriven by the DUT the whole time.
- Back-to-back: writes 0x55 to A, 0x99 to B, then a read of C (bench drives 0xBD) with req_valid held high -> three bus cycles with CS high at least 1 cycle between them, responses 6 cycles apart, final rsp_rdata = 0xBD.
- RST asserted in the second STROBE cycle of a write -> WR and CS = 1 next edge, no rsp_valid, a fresh request afterwards completes normally.
- Parameters SETUP=2, PULSE=3, HOLD=2, RECOV=3 -> measured pin phases match exactly; accept-to-accept = 11 cycles.
